// File: rtl/config_sequencer.sv
// config_sequencer: schedules runs of the serial configuration shifter.
// Host program requests (rising edge of host_req) have strict priority over
// the periodic SEU scrub timer. Each run issues a one-cycle cfg_start with a
// stable cfg_bank, then supervises the shifter busy handshake with a timeout.
// Optional build macro CFG_SEQ_ALT_BANK_EN: scrub runs alternate banks
// instead of reusing the last host bank.
module config_sequencer #(
  parameter int PRESCALE_W = 26,
  parameter int TIMEOUT    = 4096,
  parameter int CNT_W      = 8
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             host_req,
  input  logic             host_bank,
  input  logic             scrub_en,
  input  logic             cfg_busy,
  input  logic             err_clr,
  output logic             cfg_start,
  output logic             cfg_bank,
  output logic             busy,
  output logic [CNT_W-1:0] run_count,
  output logic             err_timeout
);

  localparam int              TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;

  state_t                state, state_nx;
  logic                  host_req_q, host_req_d, host_rise;
  logic                  host_pend, host_bank_q;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  scrub_tick, scrub_pend, scrub_bank;
  logic [TO_W-1:0]       to_cnt;
  logic                  grant_host, grant_scrub, to_clr, tmo, done_ok;

  // host_req is registered, then edge-detected on the registered copy
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      host_req_q <= 1'b0;
      host_req_d <= 1'b0;
    end else begin
      host_req_q <= host_req;
      host_req_d <= host_req_q;
    end
  end

  assign host_rise = host_req_q & ~host_req_d;

  // Single-deep host pending flag; a new edge wins over a same-cycle grant
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      host_pend   <= 1'b0;
      host_bank_q <= 1'b0;
    end else begin
      if (host_rise) begin
        host_pend   <= 1'b1;
        host_bank_q <= host_bank;
      end else if (grant_host) begin
        host_pend   <= 1'b0;
      end
    end
  end

  // Scrub prescaler: free-runs while enabled, held at zero otherwise
  always_ff @(posedge clkin or posedge rst) begin
    if (rst)           pre_cnt <= '0;
    else if (scrub_en) pre_cnt <= pre_cnt + PRESCALE_W'(1);
    else               pre_cnt <= '0;
  end

  assign scrub_tick = scrub_en && (pre_cnt == '1);

  // Single-deep scrub pending flag; extra ticks coalesce
  always_ff @(posedge clkin or posedge rst) begin
    if (rst)              scrub_pend <= 1'b0;
    else if (scrub_tick)  scrub_pend <= 1'b1;
    else if (grant_scrub) scrub_pend <= 1'b0;
  end

`ifdef CFG_SEQ_ALT_BANK_EN
  logic alt_bank;

  // Scrub bank toggles after every scrub grant; host runs leave it alone
  always_ff @(posedge clkin or posedge rst) begin
    if (rst)              alt_bank <= 1'b0;
    else if (grant_scrub) alt_bank <= ~alt_bank;
  end

  assign scrub_bank = alt_bank;
`else
  assign scrub_bank = host_bank_q;
`endif

  // State register
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state, grant arbitration and handshake supervision
  always_comb begin
    state_nx    = state;
    grant_host  = 1'b0;
    grant_scrub = 1'b0;
    to_clr      = 1'b0;
    tmo         = 1'b0;
    done_ok     = 1'b0;
    case (state)
      IDLE: begin
        if (host_pend) begin
          grant_host = 1'b1;
          state_nx   = LAUNCH;
        end else if (scrub_pend) begin
          grant_scrub = 1'b1;
          state_nx    = LAUNCH;
        end
      end
      LAUNCH: begin
        to_clr   = 1'b1;
        state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (cfg_busy) begin
          to_clr   = 1'b1;
          state_nx = WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          tmo      = 1'b1;
          state_nx = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!cfg_busy) begin
          done_ok  = 1'b1;
          state_nx = IDLE;
        end else if (to_cnt == TO_LAST) begin
          tmo      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Timeout counter; only meaningful in the WAIT states, free-runs elsewhere
  always_ff @(posedge clkin or posedge rst) begin
    if (rst)         to_cnt <= '0;
    else if (to_clr) to_cnt <= '0;
    else             to_cnt <= to_cnt + TO_W'(1);
  end

  // Registered start pulse and bank select captured at grant
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      cfg_start <= 1'b0;
      cfg_bank  <= 1'b0;
    end else begin
      cfg_start <= (state_nx == LAUNCH);
      if (grant_host)       cfg_bank <= host_bank_q;
      else if (grant_scrub) cfg_bank <= scrub_bank;
    end
  end

  // Completed-run counter and sticky timeout flag (set beats clear)
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      run_count   <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (done_ok) run_count <= run_count + CNT_W'(1);
      if (tmo)          err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule
